// File: rtl/fp8_pkg.sv
// fp8_pkg: shared state encoding and constants for the FP8 multiplier sequencer
package fp8_pkg;
  typedef enum logic [2:0] {
    A_HI,
    A_LO,
    B_HI,
    B_LO,
    ISSUE,
    WAIT,
    OUT_HI,
    OUT_LO
  } seq_state_t;
  localparam logic [7:0] FP8_NAN      = 8'hFF;
  localparam logic [7:0] RESULT_RESET = 8'hFF;
  function automatic logic [3:0] nib_sel(input logic [7:0] v, input logic hi);
    return hi ? v[7:4] : v[3:0];
  endfunction
endpackage

// File: rtl/fp8_seq_watchdog.sv
// fp8_seq_watchdog: cleared on load, counts while enabled, flags the LIMIT-th enabled cycle
module fp8_seq_watchdog #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  logic [7:0] cnt_q, cnt_d;
  // clear on load, otherwise count enabled cycles
  always_comb cnt_d = load_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign expire_o = en_i && (cnt_q == 8'(LIMIT - 1));
endmodule

// File: rtl/fp8_mul_sequencer.sv
// fp8_mul_sequencer: nibble-serial operand loader and result streamer for an FP8 multiplier core (watchdog under FP8SEQ_TIMEOUT_EN)
module fp8_mul_sequencer
  import fp8_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [3:0] data_i,
  output logic       core_start_o,
  output logic [7:0] core_a_o,
  output logic [7:0] core_b_o,
  input  logic       core_done_i,
  input  logic [7:0] core_c_i,
  output logic [3:0] out_data_o,
  output logic       out_valid_o,
  output logic       busy_o,
  output logic       err_o
);
  seq_state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic       err_q, err_d;
  logic       expire;
`ifdef FP8SEQ_TIMEOUT_EN
  fp8_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (state_q == ISSUE),
    .en_i    (state_q == WAIT),
    .expire_o(expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^8'(TIMEOUT_CYCLES);
  assign expire     = 1'b0;
`endif
  // next-state, operand capture and result capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      A_HI: if (enable_i) begin
        a_d[7:4] = data_i;
        err_d    = 1'b0;
        state_d  = A_LO;
      end
      A_LO: if (enable_i) begin
        a_d[3:0] = data_i;
        state_d  = B_HI;
      end
      B_HI: if (enable_i) begin
        b_d[7:4] = data_i;
        state_d  = B_LO;
      end
      B_LO: if (enable_i) begin
        b_d[3:0] = data_i;
        state_d  = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (core_done_i) begin
        res_d   = core_c_i;
        state_d = OUT_HI;
      end else if (expire) begin
        res_d   = FP8_NAN;
        err_d   = 1'b1;
        state_d = OUT_HI;
      end
      OUT_HI: state_d = enable_i ? OUT_LO : OUT_HI;
      OUT_LO: state_d = enable_i ? A_HI : OUT_LO;
      default: state_d = A_HI;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= A_HI;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= RESULT_RESET;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  assign core_start_o = state_q == ISSUE;
  assign busy_o       = (state_q == ISSUE) || (state_q == WAIT);
  assign out_valid_o  = (state_q == OUT_HI) || (state_q == OUT_LO);
  assign out_data_o   = out_valid_o ? nib_sel(res_q, state_q == OUT_HI) : 4'hF;
  assign core_a_o     = a_q;
  assign core_b_o     = b_q;
  assign err_o        = err_q;
endmodule

// File: doc/fp8_mul_sequencer.md
# fp8_mul_sequencer

Nibble-serial front-end controller that sequences one FP8 (E4M3) multiplier core. It assembles operands A and B from four enable-qualified 4-bit writes, issues a single-cycle start to the core and waits for its done handshake. It then streams the 8-bit product back out as two nibbles. It sits between the top-level pin mapping and the multiplier core. The top maps io_out[3:0]=out_data, io_out[4]=out_valid, io_out[5]=busy and io_out[6]=err.

## Interface
- TIMEOUT_CYCLES, 15: maximum number of WAIT cycles before the watchdog fires (only used with the macro); legal range 1..255.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to its idle load state.
- enable  in  1  strobe; qualifies a data nibble in load states and consumes a nibble in output states.
- data  in  4  operand nibble.
- core_start  out  1  one-cycle pulse that launches the core.
- core_a, core_b  out  8  operands to the core; held stable from ISSUE until the core completes.
- core_done  in  1  core completion; sampled only in WAIT.
- core_c  in  8  core product; valid while core_done=1.
- out_data  out  4  result nibble.
- out_valid  out  1  out_data holds a result nibble.
- busy  out  1  high in ISSUE and WAIT.
- err  out  1  sticky timeout flag, cleared on the next accepted A_HI nibble.

## Operation
- States, in order: A_HI, A_LO, B_HI, B_LO, ISSUE, WAIT, OUT_HI, OUT_LO.
- Load states A_HI through B_LO:
  - A load state with enable=1 at a posedge captures data into the matching half: A[7:4], A[3:0], B[7:4], B[3:0].
  - It then advances one state.
  - enable=0 holds the state.
- ISSUE: core_start=1 for exactly this cycle; unconditional transition to WAIT.
- WAIT:
  - core_done=1 at a posedge: capture core_c into the result register and go to OUT_HI.
  - enable is ignored in WAIT.
- OUT_HI: out_valid=1, out_data=result[7:4]; enable=1 goes to OUT_LO.
- OUT_LO: out_valid=1, out_data=result[3:0]; enable=1 goes to A_HI. data is ignored in both output states.
- core_done outside WAIT is ignored, including a stale done arriving after a reset.
- The block does no floating-point interpretation; the result is core_c verbatim, or the NaN constant on timeout.
- Reset mid-operation discards partial operands and any pending result. core_start drops immediately (asynchronously).

## Timing
- Reset values:
  - state=A_HI; core_start=0; core_a=core_b=8'h00; result=8'hFF.
  - out_data=4'hF; out_valid=0; busy=0; err=0.
- Minimum latency from the 4th accepted nibble to out_valid is 3 cycles: ISSUE, one WAIT cycle with core_done already high, then OUT_HI.
- A zero-latency core must therefore hold done into the cycle after start.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- enable held high continuously advances one state per cycle through all load and output states.

## Configuration
- FP8SEQ_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - After TIMEOUT_CYCLES WAIT cycles without core_done, the result is forced to 8'hFF (NaN), err is set, and the block goes to OUT_HI.
  - core_done arriving in the same cycle as expiry wins: core_c is captured and err stays 0.
- FP8SEQ_TIMEOUT_EN undefined: WAIT waits forever, err is tied 0, and no counter logic exists.

## Structure
- Shared package fp8_pkg:
  - state enum seq_state_t (3 bits).
  - FP8_NAN = 8'hFF.
  - RESULT_RESET = 8'hFF.
- Sub-module fp8_seq_watchdog: load/enable/expire counter, instantiated only under FP8SEQ_TIMEOUT_EN.
- The multiplier core is external and is not instantiated inside this block.

## Test plan
- Basic product, bench core with latency 2:
  - Nibbles 3,8,4,0 with enable=1 give core_a=8'h38 and core_b=8'h40; the bench core returns 8'h40.
  - Required: core_start is a single pulse, and out_data reads 4,0 on two enable pulses.
- Gaps between nibbles:
  - enable is low for 3 cycles between each nibble.
  - Required: state holds and the operands match the no-gap case exactly.
- Reset mid-operation:
  - Assert reset after the B_HI nibble.
  - Required: outputs return to reset values asynchronously (out_data=F, busy=0).
  - A fresh 4-nibble sequence then produces the correct product; a stale core_done injected in A_HI is ignored.
- Back-to-back operations with enable held high:
  - Two operations: 8'h38×8'h38, then 8'hC0×8'h38; the bench core returns 8'h38, then 8'hC0.
  - Required: no lost nibbles, and out_data reads 3,8 then C,0.
- Timeout (macro on, TIMEOUT_CYCLES=4, core never asserts done):
  - Required: the result reads F,F and err=1; err clears on the next accepted A_HI nibble.
  - Done arriving exactly on the expiry cycle yields core_c with err=0.
- Macro off, core latency 40:
  - Required: WAIT persists, busy stays high for 41 cycles, and the result is captured correctly.
